// File: rtl/rr_gate_arbiter.sv
// Round-robin arbiter with a one-entry output buffer. Drives a zero-gated
// concatenated bus so a downstream OR reduction yields the granted payload.
module rr_gate_arbiter #(
    parameter int WIDTH    = 32,
    parameter int NINPUTS  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NINPUTS-1:0]         req_valid,
    input  logic [WIDTH*NINPUTS-1:0]   req_data,
    output logic [NINPUTS-1:0]         req_ready,
    output logic [WIDTH*NINPUTS-1:0]   gated_bus,
    output logic [NINPUTS-1:0]         grant,
    output logic [ID_WIDTH-1:0]        grant_id,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]          state;
    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] scan_idx;
    logic [ID_WIDTH-1:0] win_id;
    logic [ID_WIDTH-1:0] next_ptr;
    logic [NINPUTS-1:0]  win_onehot;
    logic [WIDTH-1:0]    win_data;
    logic [WIDTH-1:0]    held;
    logic                found;
    logic                can_accept;
    logic                accept;

    // Scan from ptr upward (mod NINPUTS); the first valid requester wins.
    always_comb begin
        found    = 1'b0;
        win_id   = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NINPUTS; k++) begin
            scan_idx = ID_WIDTH'((int'(ptr) + int'(k)) % NINPUTS);
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                win_id = scan_idx;
            end
        end
    end

    always_comb begin
        win_onehot         = '0;
        win_onehot[win_id] = found;
    end

    assign win_data   = req_data[int'(win_id)*WIDTH +: WIDTH];
    assign next_ptr   = (win_id == ID_WIDTH'(NINPUTS - 1)) ? '0 : win_id + 1'b1;
    assign can_accept = (state == ST_EMPTY) || out_ready;

    // Qualified by reset so no strobe leaks out while the block is held in reset.
    assign accept    = found && can_accept && reset;
    assign req_ready = accept ? win_onehot : '0;
    assign out_valid = (state == ST_FULL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_EMPTY;
            ptr      <= '0;
            held     <= '0;
            grant    <= '0;
            grant_id <= '0;
        end else if (accept) begin
            state    <= ST_FULL;
            ptr      <= next_ptr;
            held     <= win_data;
            grant    <= win_onehot;
            grant_id <= win_id;
        end else if (state == ST_FULL && out_ready) begin
            state    <= ST_EMPTY;
            held     <= '0;
            grant    <= '0;
            grant_id <= '0;
        end
    end

    always_comb begin
        gated_bus = '0;
        for (int unsigned j = 0; j < NINPUTS; j++) begin
            gated_bus[j*WIDTH +: WIDTH] = grant[j] ? held : '0;
        end
    end

endmodule

// File: doc/rr_gate_arbiter.md
Name: rr_gate_arbiter

Overview:
- Round-robin arbiter and one-entry output buffer for NINPUTS requesters, each offering a WIDTH-bit payload.
- Sits directly upstream of the OR-mode logic tree bus reducer.
- Emits a NINPUTS*WIDTH concatenated bus in which only the granted slot carries data and every other slot is forced to zero. The downstream bitwise OR reduction therefore yields the granted payload.
- Used for shared writeback/result buses between execution units.

Parameters:
- WIDTH, 32, payload width per requester.
- NINPUTS, 4, number of requesters (2..16).
- ID_WIDTH, 2, width of grant_id; must be >= ceil(log2(NINPUTS)).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NINPUTS  per-requester valid.
- req_data  input  WIDTH*NINPUTS  requester j payload in bits [j*WIDTH +: WIDTH].
- req_ready  output  NINPUTS  one-hot (or zero) accept strobe.
- gated_bus  output  WIDTH*NINPUTS  slot j = held payload if grant[j], else zero; feeds the OR reducer.
- grant  output  NINPUTS  one-hot registered owner of the held entry; zero when empty.
- grant_id  output  ID_WIDTH  binary index of grant; zero when empty.
- out_valid  output  1  held entry valid.
- out_ready  input  1  consumer accepts the held entry this cycle.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - out_valid=0, grant=0, grant_id=0, gated_bus=0, req_ready=0.
  - Round-robin pointer ptr=0.
- States:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- can_accept = EMPTY or (FULL and out_ready).
- Selection (combinational):
  - winner = first j with req_valid[j], scanning ptr, ptr+1, ... mod NINPUTS.
  - req_ready[winner]=1 iff can_accept and any req_valid; all other bits 0.
  - req_ready never depends on req_data.
- Acceptance edge (req_valid[j] & req_ready[j]):
  - Register req_data slot j.
  - grant <= one-hot j; grant_id <= j; out_valid <= 1.
  - ptr <= (j+1) mod NINPUTS; wrap from NINPUTS-1 to 0.
- Latency: payload accepted at edge N appears on gated_bus/out_valid after edge N (registered, 1 cycle).
- Transitions:
  - EMPTY + any valid -> FULL.
  - FULL + out_ready + any valid -> FULL with new owner. Back-to-back operation, one transfer per cycle.
  - FULL + out_ready + no valid -> EMPTY. grant, grant_id and gated_bus are cleared to zero.
  - FULL + !out_ready -> FULL. Outputs stable; req_ready all zero.
- gated_bus invariant: at most one nonzero slot, and that slot equals grant. Cleared slots are all-zero, never X.
- ptr advances only on acceptance; it is unchanged while stalled or idle.
- A requester deasserting req_valid without a handshake is legal and causes no state change.
- Reset mid-transfer discards the held entry. No req_ready is asserted during reset.

Test Plan:
- Single request:
  - Stimulus: after reset, req_valid=4'b0100, data2=0xDEADBEEF, out_ready=1.
  - Required: req_ready=4'b0100 same cycle; next cycle out_valid=1, grant=4'b0100, grant_id=2, slot2=0xDEADBEEF, slots 0/1/3=0, OR of slots=0xDEADBEEF.
- Round-robin fairness:
  - Stimulus: all four valid continuously, out_ready=1.
  - Required: grant_id sequence 0,1,2,3,0,1 on consecutive cycles; out_valid held 1.
- Backpressure:
  - Stimulus: FULL holding requester 1, out_ready=0 for 5 cycles with req_valid=4'b1111.
  - Required: req_ready=0, gated_bus/grant unchanged. When out_ready=1, requester 2 is granted next.
- Drain to empty:
  - Stimulus: FULL, out_ready=1, req_valid=0.
  - Required: next cycle out_valid=0, grant=0, gated_bus=0. ptr keeps its last value; a later request at ptr's index is granted first.
- Async reset:
  - Stimulus: assert reset low mid-cycle while FULL with grant_id=3.
  - Required: immediately out_valid=0, gated_bus=0, req_ready=0. After release, req_valid=4'b1001 grants requester 0.
- Wrap-around:
  - Stimulus: last grant 3, then req_valid=4'b1001.
  - Required: requester 0 granted (ptr wrapped to 0), then requester 3.
